// File: rtl/alu_seq_top.sv
// alu_seq_top: handshaked 16-function ALU with signed/unsigned mode and an
// iterative restoring divider (quotient + remainder, divide-by-zero report).
module alu_seq_top #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     A,
  input  logic [DATA_WIDTH-1:0]     B,
  input  logic [3:0]                ALU_FUNC,
  input  logic                      signed_mode,
  output logic                      out_valid,
  output logic [2*DATA_WIDTH-1:0]   Arith_OUT,
  output logic [DATA_WIDTH-1:0]     Rem_OUT,
  output logic [DATA_WIDTH-1:0]     Logic_OUT,
  output logic [1:0]                CMP_OUT,
  output logic [DATA_WIDTH-1:0]     SHIFT_OUT,
  output logic                      Arith_flag,
  output logic                      Logic_flag,
  output logic                      CMP_flag,
  output logic                      SHIFT_flag,
  output logic                      div_zero
);

  localparam int unsigned W   = DATA_WIDTH;
  localparam int unsigned W2  = 2 * DATA_WIDTH;
  localparam int unsigned WP1 = DATA_WIDTH + 1;
  localparam int unsigned CW  = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt_r;
  logic [W-1:0]   rem_r;
  logic [W-1:0]   quo_r;
  logic [W-1:0]   dvsr_r;
  logic [W-1:0]   a_r;
  logic           sgn_r;
  logic           q_neg_r;
  logic           r_neg_r;
  logic           dz_r;

  logic [W2-1:0]  ax;
  logic [W2-1:0]  bx;
  logic [W2-1:0]  arith_res;
  logic [W-1:0]   logic_res;
  logic [1:0]     cmp_res;
  logic [W-1:0]   shift_res;
  logic [1:0]     unit;
  logic           is_div;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     rem_sh;
  logic           ge;
  logic [W-1:0]   rem_nx;
  logic [W-1:0]   quo_nx;
  logic [W:0]     q_ext;
  logic [W:0]     q_fix;
  logic [W2-1:0]  q_out;
  logic [W-1:0]   r_fix;

  // Single-cycle function results, operand magnitudes, divider step and sign fix
  always_comb begin
    ax        = signed_mode ? {{W{A[W-1]}}, A} : {{W{1'b0}}, A};
    bx        = signed_mode ? {{W{B[W-1]}}, B} : {{W{1'b0}}, B};
    unit      = ALU_FUNC[3:2];
    is_div    = (ALU_FUNC == 4'b0011);
    arith_res = '0;
    logic_res = '0;
    cmp_res   = 2'd0;
    shift_res = '0;

    case (ALU_FUNC[1:0])
      2'b00:   arith_res = ax + bx;
      2'b01:   arith_res = ax - bx;
      2'b10:   arith_res = ax * bx;
      default: arith_res = '0;
    endcase

    case (ALU_FUNC[1:0])
      2'b00:   logic_res = A & B;
      2'b01:   logic_res = A | B;
      2'b10:   logic_res = ~(A & B);
      default: logic_res = ~(A | B);
    endcase

    // Extended operands keep their mode's ordering under a signed compare
    case (ALU_FUNC[1:0])
      2'b00:   cmp_res = 2'd0;
      2'b01:   cmp_res = (ax == bx) ? 2'd1 : 2'd0;
      2'b10:   cmp_res = ($signed(ax) > $signed(bx)) ? 2'd2 : 2'd0;
      default: cmp_res = ($signed(ax) < $signed(bx)) ? 2'd3 : 2'd0;
    endcase

    case (ALU_FUNC[1:0])
      2'b00:   shift_res = {signed_mode & A[W-1], A[W-1:1]};
      2'b01:   shift_res = {A[W-2:0], 1'b0};
      2'b10:   shift_res = {signed_mode & B[W-1], B[W-1:1]};
      default: shift_res = {B[W-2:0], 1'b0};
    endcase

    a_mag  = (signed_mode && A[W-1]) ? (~A + W'(1)) : A;
    b_mag  = (signed_mode && B[W-1]) ? (~B + W'(1)) : B;

    rem_sh = {rem_r, quo_r[W-1]};
    ge     = (rem_sh >= {1'b0, dvsr_r});
    rem_nx = ge ? W'(rem_sh - {1'b0, dvsr_r}) : rem_sh[W-1:0];
    quo_nx = {quo_r[W-2:0], ge};

    q_ext  = {1'b0, quo_r};
    q_fix  = q_neg_r ? (~q_ext + WP1'(1)) : q_ext;
    q_out  = sgn_r ? {{(W-1){q_fix[W]}}, q_fix} : {{W{1'b0}}, quo_r};
    r_fix  = r_neg_r ? (~rem_r + W'(1)) : rem_r;
  end

  // Control FSM, divider datapath and registered result outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      cnt_r      <= '0;
      rem_r      <= '0;
      quo_r      <= '0;
      dvsr_r     <= '0;
      a_r        <= '0;
      sgn_r      <= 1'b0;
      q_neg_r    <= 1'b0;
      r_neg_r    <= 1'b0;
      dz_r       <= 1'b0;
      out_valid  <= 1'b0;
      Arith_OUT  <= '0;
      Rem_OUT    <= '0;
      Logic_OUT  <= '0;
      CMP_OUT    <= 2'd0;
      SHIFT_OUT  <= '0;
      Arith_flag <= 1'b0;
      Logic_flag <= 1'b0;
      CMP_flag   <= 1'b0;
      SHIFT_flag <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      Arith_flag <= 1'b0;
      Logic_flag <= 1'b0;
      CMP_flag   <= 1'b0;
      SHIFT_flag <= 1'b0;
      div_zero   <= 1'b0;

      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            if (is_div) begin
              // Capture everything the divide needs; later operand changes are ignored
              in_ready <= 1'b0;
              a_r      <= A;
              sgn_r    <= signed_mode;
              q_neg_r  <= signed_mode & (A[W-1] ^ B[W-1]);
              r_neg_r  <= signed_mode & A[W-1];
              rem_r    <= '0;
              quo_r    <= a_mag;
              dvsr_r   <= b_mag;
              cnt_r    <= '0;
              dz_r     <= (B == '0);
              state    <= (B == '0) ? DONE : DIV;
            end else begin
              out_valid  <= 1'b1;
              Arith_OUT  <= (unit == 2'b00) ? arith_res : '0;
              Logic_OUT  <= (unit == 2'b01) ? logic_res : '0;
              CMP_OUT    <= (unit == 2'b10) ? cmp_res   : 2'd0;
              SHIFT_OUT  <= (unit == 2'b11) ? shift_res : '0;
              Rem_OUT    <= '0;
              Arith_flag <= (unit == 2'b00);
              Logic_flag <= (unit == 2'b01);
              CMP_flag   <= (unit == 2'b10);
              SHIFT_flag <= (unit == 2'b11);
            end
          end
        end

        DIV: begin
          in_ready <= 1'b0;
          rem_r    <= rem_nx;
          quo_r    <= quo_nx;
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == CW'(W - 1)) begin
            state <= DONE;
          end
        end

        DONE: begin
          in_ready   <= 1'b1;
          state      <= IDLE;
          out_valid  <= 1'b1;
          Arith_flag <= 1'b1;
          Logic_OUT  <= '0;
          CMP_OUT    <= 2'd0;
          SHIFT_OUT  <= '0;
          if (dz_r) begin
            Arith_OUT <= '1;
            Rem_OUT   <= a_r;
            div_zero  <= 1'b1;
          end else begin
            Arith_OUT <= q_out;
            Rem_OUT   <= r_fix;
          end
        end

        default: begin
          in_ready <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_top.sv
// Self-checking bench for alu_seq_top (DATA_WIDTH = 8): directed table,
// multi-cycle corner sequences and randomized ops against a reference model.
module tb_alu_seq_top;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic [3:0]  func;
  logic        sm;
  logic        out_valid;
  logic [15:0] arith_out;
  logic [7:0]  rem_out;
  logic [7:0]  logic_out;
  logic [1:0]  cmp_out;
  logic [7:0]  shift_out;
  logic        arith_flag;
  logic        logic_flag;
  logic        cmp_flag;
  logic        shift_flag;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] arith;
    logic [7:0]  rem;
    logic [7:0]  lgc;
    logic [1:0]  cmp;
    logic [7:0]  shf;
    logic [3:0]  flags;
    logic        dz;
    int          d;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] f;
    logic       sm;
    exp_t       e;
  } vec_t;

  alu_seq_top #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (a_in),
    .B          (b_in),
    .ALU_FUNC   (func),
    .signed_mode(sm),
    .out_valid  (out_valid),
    .Arith_OUT  (arith_out),
    .Rem_OUT    (rem_out),
    .Logic_OUT  (logic_out),
    .CMP_OUT    (cmp_out),
    .SHIFT_OUT  (shift_out),
    .Arith_flag (arith_flag),
    .Logic_flag (logic_flag),
    .CMP_flag   (cmp_flag),
    .SHIFT_flag (shift_flag),
    .div_zero   (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] f, input logic s);
    exp_t e;
    int av;
    int bv;
    av = s ? int'($signed(a)) : int'(a);
    bv = s ? int'($signed(b)) : int'(b);
    e = '{arith: 16'h0, rem: 8'h0, lgc: 8'h0, cmp: 2'd0, shf: 8'h0,
          flags: 4'b0000, dz: 1'b0, d: 0};
    if (f < 4) e.flags = 4'b1000;
    else if (f < 8) e.flags = 4'b0100;
    else if (f < 12) e.flags = 4'b0010;
    else e.flags = 4'b0001;
    case (f)
      4'd0:  e.arith = 16'(av + bv);
      4'd1:  e.arith = 16'(av - bv);
      4'd2:  e.arith = 16'(av * bv);
      4'd3: begin
        if (bv == 0) begin
          e.arith = 16'hFFFF;
          e.rem   = a;
          e.dz    = 1'b1;
          e.d     = 1;
        end else begin
          e.arith = 16'(av / bv);
          e.rem   = 8'(av % bv);
          e.d     = 9;
        end
      end
      4'd4:  e.lgc = a & b;
      4'd5:  e.lgc = a | b;
      4'd6:  e.lgc = ~(a & b);
      4'd7:  e.lgc = ~(a | b);
      4'd8:  e.cmp = 2'd0;
      4'd9:  e.cmp = (av == bv) ? 2'd1 : 2'd0;
      4'd10: e.cmp = (av > bv) ? 2'd2 : 2'd0;
      4'd11: e.cmp = (av < bv) ? 2'd3 : 2'd0;
      4'd12: e.shf = 8'(av >>> 1);
      4'd13: e.shf = 8'(av << 1);
      4'd14: e.shf = 8'(bv >>> 1);
      default: e.shf = 8'(bv << 1);
    endcase
    return e;
  endfunction

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                              input logic s, input logic [15:0] ar, input logic [7:0] rm,
                              input logic [7:0] lg, input logic [1:0] cm, input logic [7:0] sh,
                              input logic [3:0] fl, input logic dz, input int d);
    vec_t v;
    v.a = a; v.b = b; v.f = f; v.sm = s;
    v.e = '{arith: ar, rem: rm, lgc: lg, cmp: cm, shf: sh, flags: fl, dz: dz, d: d};
    return v;
  endfunction

  // Issue one op when ready, wait (bounded) for its result, compare everything
  task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] f, input logic s, input exp_t e);
    int guard;
    int d;
    int low;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, " in_ready before issue"}, 32'(in_ready), 32'd1);
    a_in = a; b_in = b; func = f; sm = s; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    d = 0;
    low = 0;
    while (!out_valid && d < 100) begin
      if (!in_ready) low++;
      @(posedge clk);
      #1;
      d++;
    end
    chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
    chk({nm, " latency"}, 32'(d), 32'(e.d));
    chk({nm, " in_ready low cycles"}, 32'(low), 32'(e.d));
    chk({nm, " in_ready at result"}, 32'(in_ready), 32'd1);
    chk({nm, " Arith_OUT"}, 32'(arith_out), 32'(e.arith));
    chk({nm, " Rem_OUT"}, 32'(rem_out), 32'(e.rem));
    chk({nm, " Logic_OUT"}, 32'(logic_out), 32'(e.lgc));
    chk({nm, " CMP_OUT"}, 32'(cmp_out), 32'(e.cmp));
    chk({nm, " SHIFT_OUT"}, 32'(shift_out), 32'(e.shf));
    chk({nm, " flags"}, 32'({arith_flag, logic_flag, cmp_flag, shift_flag}), 32'(e.flags));
    chk({nm, " div_zero"}, 32'(div_zero), 32'(e.dz));
    @(posedge clk);
    #1;
    chk({nm, " out_valid pulse end"}, 32'(out_valid), 32'd0);
    chk({nm, " flags pulse end"},
        32'({arith_flag, logic_flag, cmp_flag, shift_flag, div_zero}), 32'd0);
    chk({nm, " Arith_OUT hold"}, 32'(arith_out), 32'(e.arith));
  endtask

  vec_t vt[$];

  initial begin
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [3:0]  rf;
    logic        rs;
    logic [7:0]  bb_a[3];
    logic [7:0]  bb_b[3];
    logic [3:0]  bb_f[3];
    logic [15:0] bb_e[3];
    int          d;
    int          seen;

    rst = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; func = '0; sm = 1'b0;

    // Directed vectors with hand-derived expectations (W = 8)
    vt.push_back(mk(8'hFB, 8'hFD, 4'd0,  1'b1, 16'hFFF8, 8'h00, 8'h00, 2'd0, 8'h00, 4'b1000, 1'b0, 0));
    vt.push_back(mk(8'h09, 8'hFD, 4'd1,  1'b1, 16'h000C, 8'h00, 8'h00, 2'd0, 8'h00, 4'b1000, 1'b0, 0));
    vt.push_back(mk(8'hF7, 8'h03, 4'd2,  1'b1, 16'hFFE5, 8'h00, 8'h00, 2'd0, 8'h00, 4'b1000, 1'b0, 0));
    vt.push_back(mk(8'h03, 8'h05, 4'd1,  1'b0, 16'hFFFE, 8'h00, 8'h00, 2'd0, 8'h00, 4'b1000, 1'b0, 0));
    vt.push_back(mk(8'hF7, 8'h03, 4'd3,  1'b1, 16'hFFFD, 8'h00, 8'h00, 2'd0, 8'h00, 4'b1000, 1'b0, 9));
    vt.push_back(mk(8'hF9, 8'h02, 4'd3,  1'b1, 16'hFFFD, 8'hFF, 8'h00, 2'd0, 8'h00, 4'b1000, 1'b0, 9));
    vt.push_back(mk(8'h80, 8'hFF, 4'd3,  1'b1, 16'h0080, 8'h00, 8'h00, 2'd0, 8'h00, 4'b1000, 1'b0, 9));
    vt.push_back(mk(8'hC8, 8'h07, 4'd3,  1'b0, 16'h001C, 8'h04, 8'h00, 2'd0, 8'h00, 4'b1000, 1'b0, 9));
    vt.push_back(mk(8'h05, 8'h00, 4'd3,  1'b1, 16'hFFFF, 8'h05, 8'h00, 2'd0, 8'h00, 4'b1000, 1'b1, 1));
    vt.push_back(mk(8'hE5, 8'h77, 4'd10, 1'b1, 16'h0000, 8'h00, 8'h00, 2'd0, 8'h00, 4'b0010, 1'b0, 0));
    vt.push_back(mk(8'hE5, 8'h77, 4'd10, 1'b0, 16'h0000, 8'h00, 8'h00, 2'd2, 8'h00, 4'b0010, 1'b0, 0));
    vt.push_back(mk(8'hE5, 8'h77, 4'd11, 1'b1, 16'h0000, 8'h00, 8'h00, 2'd3, 8'h00, 4'b0010, 1'b0, 0));
    vt.push_back(mk(8'hF5, 8'hF5, 4'd9,  1'b1, 16'h0000, 8'h00, 8'h00, 2'd1, 8'h00, 4'b0010, 1'b0, 0));
    vt.push_back(mk(8'hE5, 8'h77, 4'd8,  1'b1, 16'h0000, 8'h00, 8'h00, 2'd0, 8'h00, 4'b0010, 1'b0, 0));
    vt.push_back(mk(8'hE5, 8'h77, 4'd12, 1'b1, 16'h0000, 8'h00, 8'h00, 2'd0, 8'hF2, 4'b0001, 1'b0, 0));
    vt.push_back(mk(8'hE5, 8'h77, 4'd12, 1'b0, 16'h0000, 8'h00, 8'h00, 2'd0, 8'h72, 4'b0001, 1'b0, 0));
    vt.push_back(mk(8'hE5, 8'h77, 4'd13, 1'b1, 16'h0000, 8'h00, 8'h00, 2'd0, 8'hCA, 4'b0001, 1'b0, 0));
    vt.push_back(mk(8'hE5, 8'h77, 4'd4,  1'b1, 16'h0000, 8'h00, 8'h65, 2'd0, 8'h00, 4'b0100, 1'b0, 0));
    vt.push_back(mk(8'hE5, 8'h77, 4'd5,  1'b1, 16'h0000, 8'h00, 8'hF7, 2'd0, 8'h00, 4'b0100, 1'b0, 0));
    vt.push_back(mk(8'hE5, 8'h77, 4'd6,  1'b1, 16'h0000, 8'h00, 8'h9A, 2'd0, 8'h00, 4'b0100, 1'b0, 0));
    vt.push_back(mk(8'hE5, 8'h77, 4'd7,  1'b1, 16'h0000, 8'h00, 8'h08, 2'd0, 8'h00, 4'b0100, 1'b0, 0));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset outputs", 32'({arith_out, rem_out, logic_out}), 32'd0);
    chk("reset cmp/shift/flags",
        32'({cmp_out, shift_out, arith_flag, logic_flag, cmp_flag, shift_flag, div_zero}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after reset release", 32'(in_ready), 32'd1);

    for (int i = 0; i < vt.size(); i++) begin
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].f, vt[i].sm, vt[i].e);
    end

    // Back-to-back adds/sub/mul: one result per cycle
    bb_a = '{8'hFB, 8'h09, 8'hF7};
    bb_b = '{8'hFD, 8'hFD, 8'h03};
    bb_f = '{4'd0, 4'd1, 4'd2};
    bb_e = '{16'hFFF8, 16'h000C, 16'hFFE5};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_in = bb_a[i]; b_in = bb_b[i]; func = bb_f[i]; sm = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("b2b%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("b2b%0d Arith_OUT", i), 32'(arith_out), 32'(bb_e[i]));
      chk($sformatf("b2b%0d flags", i),
          32'({arith_flag, logic_flag, cmp_flag, shift_flag}), 32'b1000);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b out_valid after", 32'(out_valid), 32'd0);

    // Request during DIV is dropped; operand changes do not disturb the divide
    @(negedge clk);
    a_in = 8'hC8; b_in = 8'h07; func = 4'd3; sm = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in = 8'h11; b_in = 8'h01; sm = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    func = 4'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    d = 3;
    while (!out_valid && d < 100) begin
      @(posedge clk);
      #1;
      d++;
    end
    chk("drop latency", 32'(d), 32'd9);
    chk("drop quotient", 32'(arith_out), 32'h001C);
    chk("drop remainder", 32'(rem_out), 32'h04);
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("dropped request produced result", 32'(seen), 32'd0);

    // Reset four cycles into a divide aborts it
    @(negedge clk);
    a_in = 8'h64; b_in = 8'h07; func = 4'd3; sm = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort in_ready", 32'(in_ready), 32'd0);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort outputs", 32'({arith_out, rem_out, logic_out}), 32'd0);
    chk("abort cmp/shift/flags",
        32'({cmp_out, shift_out, arith_flag, logic_flag, cmp_flag, shift_flag, div_zero}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort in_ready after release", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("aborted divide produced result", 32'(seen), 32'd0);
    run_op("post-reset add", 8'h05, 8'h03, 4'd0, 1'b0,
           '{arith: 16'h0008, rem: 8'h00, lgc: 8'h00, cmp: 2'd0, shf: 8'h00,
             flags: 4'b1000, dz: 1'b0, d: 0});

    // Randomized ops against the reference model
    for (int i = 0; i < 80; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rf = 4'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      if (i % 10 == 0) ra = 8'h80;
      run_op($sformatf("rnd%0d a=%h b=%h f=%0d s=%0d", i, ra, rb, rf, rs),
             ra, rb, rf, rs, model(ra, rb, rf, rs));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
